// File: rtl/team_06_tremolo_ctrl.sv
// team_06_tremolo_ctrl
//
// Sequencer for the tremolo gain datapath. Each I2S sample strobe becomes a
// one-cycle gain_start request. A programmable triangle LFO supplies the
// modulation depth. The LFO advances only when a computation completes, so
// lfo_depth is stable from gain_start to gain_done. Rate/peak configuration
// is written to a shadow copy. It is committed to the active copy only when
// the LFO returns to zero, or while the effect is disabled.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active low
//   en            effect enable (low = bypass)
//   sample_tick   one-cycle strobe per audio sample
//   cfg_we        shadow config write strobe
//   cfg_rate      sample ticks per LFO step (0 behaves as 1)
//   cfg_depth_max LFO peak value
//   gain_done     datapath result-ready strobe
//   gain_start    one-cycle request to the datapath
//   lfo_depth     current modulation depth
//   lfo_dir       1 = rising, 0 = falling
//   out_valid     one-cycle strobe, datapath result may be latched
//   bypass        high while en is low (one cycle delayed)
//   cfg_pending   shadow config written but not yet committed
//   overrun       sticky, a sample_tick was dropped while busy
module team_06_tremolo_ctrl #(
  parameter int DEPTH_W = 8,
  parameter int DIV_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sample_tick,
  input  logic               cfg_we,
  input  logic [DIV_W-1:0]   cfg_rate,
  input  logic [DEPTH_W-1:0] cfg_depth_max,
  input  logic               gain_done,
  output logic               gain_start,
  output logic [DEPTH_W-1:0] lfo_depth,
  output logic               lfo_dir,
  output logic               out_valid,
  output logic               bypass,
  output logic               cfg_pending,
  output logic               overrun
);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t             state_reg, state_next;
  logic [DEPTH_W-1:0] depth_reg;
  logic               dir_reg;
  logic [DIV_W-1:0]   count_reg;
  logic [DIV_W-1:0]   active_rate_reg, shadow_rate_reg;
  logic [DEPTH_W-1:0] active_max_reg, shadow_max_reg;
  logic               out_valid_reg, bypass_reg, pending_reg, overrun_reg;

  logic               done_accept;
  logic               overrun_set;
  logic [DIV_W-1:0]   rate_last;
  logic               lfo_step;
  logic [DIV_W-1:0]   count_next;
  logic [DEPTH_W-1:0] depth_next;
  logic               dir_next;
  logic               commit;

  // Next-state logic. A disabled effect overrides everything and abandons
  // any in-flight computation.
  always_comb begin
    state_next  = state_reg;
    done_accept = 1'b0;
    overrun_set = 1'b0;
    case (state_reg)
      IDLE:  if (sample_tick) state_next = START;
      START: state_next = WAIT;
      WAIT: begin
        if (gain_done) begin
          done_accept = 1'b1;
          // A tick coinciding with completion is served immediately.
          state_next  = sample_tick ? START : IDLE;
        end else if (sample_tick) begin
          overrun_set = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!en) begin
      state_next  = IDLE;
      done_accept = 1'b0;
      overrun_set = 1'b0;
    end
  end

  // Divider: a rate of 0 behaves like 1, so the terminal count is then 0.
  always_comb begin
    rate_last  = (active_rate_reg == '0) ? '0 : active_rate_reg - DIV_W'(1);
    lfo_step   = done_accept && (count_reg >= rate_last);
    count_next = lfo_step ? '0 : count_reg + DIV_W'(1);
  end

  // Triangle step. Checking depth >= max first also recovers cleanly when
  // a newly committed peak lies below the current depth.
  always_comb begin
    depth_next = depth_reg;
    dir_next   = dir_reg;
    if (active_max_reg == '0) begin
      depth_next = '0;
      dir_next   = 1'b1;
    end else if (depth_reg >= active_max_reg) begin
      depth_next = depth_reg - DEPTH_W'(1);
      dir_next   = 1'b0;
    end else if (dir_reg) begin
      depth_next = depth_reg + DEPTH_W'(1);
    end else if (depth_reg != '0) begin
      depth_next = depth_reg - DEPTH_W'(1);
    end else begin
      depth_next = depth_reg + DEPTH_W'(1);
      dir_next   = 1'b1;
    end
  end

  // Commit only at the LFO zero point so a config change never causes a step.
  assign commit = !en || (lfo_step && (depth_next == '0));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      depth_reg       <= '0;
      dir_reg         <= 1'b1;
      count_reg       <= '0;
      active_rate_reg <= DIV_W'(1);
      shadow_rate_reg <= DIV_W'(1);
      active_max_reg  <= DEPTH_W'(16);
      shadow_max_reg  <= DEPTH_W'(16);
      out_valid_reg   <= 1'b0;
      bypass_reg      <= 1'b1;
      pending_reg     <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= done_accept;
      bypass_reg    <= !en;
      if (overrun_set) overrun_reg <= 1'b1;

      if (!en) begin
        depth_reg <= '0;
        dir_reg   <= 1'b1;
        count_reg <= '0;
      end else if (done_accept) begin
        count_reg <= count_next;
        if (lfo_step) begin
          depth_reg <= depth_next;
          dir_reg   <= dir_next;
        end
      end

      if (commit) begin
        active_rate_reg <= shadow_rate_reg;
        active_max_reg  <= shadow_max_reg;
        pending_reg     <= 1'b0;
      end
      // A write in the same cycle as a commit lands in the shadow and
      // stays pending; the commit takes the previous shadow contents.
      if (cfg_we) begin
        shadow_rate_reg <= cfg_rate;
        shadow_max_reg  <= cfg_depth_max;
        pending_reg     <= 1'b1;
      end
    end
  end

  assign gain_start  = (state_reg == START);
  assign lfo_depth   = depth_reg;
  assign lfo_dir     = dir_reg;
  assign out_valid   = out_valid_reg;
  assign bypass      = bypass_reg;
  assign cfg_pending = pending_reg;
  assign overrun     = overrun_reg;

endmodule

// File: tb/tb_team_06_tremolo_ctrl.sv
// Self-checking bench for team_06_tremolo_ctrl: a phase-based LFO model
// checked every cycle, plus directed sequences with literal expectations.
module tb_team_06_tremolo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        sample_tick = 1'b0;
  logic        cfg_we = 1'b0;
  logic [15:0] cfg_rate = '0;
  logic [7:0]  cfg_depth_max = '0;
  logic        gain_done = 1'b0;
  logic        gain_start;
  logic [7:0]  lfo_depth;
  logic        lfo_dir;
  logic        out_valid;
  logic        bypass;
  logic        cfg_pending;
  logic        overrun;

  team_06_tremolo_ctrl #(.DEPTH_W(8), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .sample_tick(sample_tick),
    .cfg_we(cfg_we), .cfg_rate(cfg_rate), .cfg_depth_max(cfg_depth_max),
    .gain_done(gain_done), .gain_start(gain_start), .lfo_depth(lfo_depth),
    .lfo_dir(lfo_dir), .out_valid(out_valid), .bypass(bypass),
    .cfg_pending(cfg_pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The LFO is a phase p in [0, 2*max); depth folds the phase into a triangle.
  int  m_phase, m_cnt, m_max, m_rate, s_max, s_rate, e_depth;
  bit  e_start, e_valid, e_dir, e_bypass, e_pend, e_ovr, m_wait;
  bit  model_ready = 1'b0;

  function automatic int fold(input int p, input int mx);
    return (p <= mx) ? p : 2 * mx - p;
  endfunction

  task automatic model_edge();
    bit o_start, o_wait, n_start, n_valid, commit;
    int eff;
    o_start = e_start; o_wait = m_wait;
    n_start = 0; n_valid = 0; commit = 0;
    if (!rst) begin
      m_phase = 0; m_cnt = 0; m_max = 16; m_rate = 1; s_max = 16; s_rate = 1;
      e_depth = 0; e_dir = 1; e_start = 0; e_valid = 0; e_bypass = 1;
      e_pend = 0; e_ovr = 0; m_wait = 0;
      return;
    end
    if (!en) begin
      m_wait = 0; m_phase = 0; e_depth = 0; e_dir = 1; m_cnt = 0; commit = 1;
    end else if (o_start) begin
      m_wait = 1;
    end else if (o_wait) begin
      if (gain_done) begin
        n_valid = 1; m_wait = 0; n_start = sample_tick;
        eff = (m_rate == 0) ? 1 : m_rate;
        m_cnt++;
        if (m_cnt == eff) begin
          m_cnt = 0;
          if (m_max == 0) begin
            m_phase = 0; e_depth = 0; e_dir = 1; commit = 1;
          end else begin
            m_phase = (m_phase + 1) % (2 * m_max);
            e_depth = fold(m_phase, m_max);
            e_dir   = (m_phase >= 1) && (m_phase <= m_max);
            if (e_depth == 0) commit = 1;
          end
        end
      end else if (sample_tick) begin
        e_ovr = 1;
      end
    end else begin
      n_start = sample_tick;
    end
    e_start = n_start; e_valid = n_valid; e_bypass = !en;
    if (commit) begin m_max = s_max; m_rate = s_rate; e_pend = 0; end
    if (cfg_we) begin s_max = int'(cfg_depth_max); s_rate = int'(cfg_rate); e_pend = 1; end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
    model_ready = 1'b1;
  end

  // Every-cycle comparison against the model, away from the clock edge.
  initial forever begin
    @(negedge clk);
    if (model_ready) begin
      chk("m_gain_start", gain_start, e_start);
      chk("m_out_valid", out_valid, e_valid);
      chk("m_depth", lfo_depth, e_depth);
      chk("m_dir", lfo_dir, e_dir);
      chk("m_bypass", bypass, e_bypass);
      chk("m_pending", cfg_pending, e_pend);
      chk("m_overrun", overrun, e_ovr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sample: tick, datapath answers lat cycles after gain_start.
  task automatic run_sample(input int lat, input int exp_depth, input string tag);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk({tag, "_start"}, gain_start, 1);
    repeat (lat) step();
    gain_done = 1'b1;
    step();
    gain_done = 1'b0;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_depth"}, lfo_depth, exp_depth);
    $display("sample %s depth=%0d dir=%0d pending=%0d", tag, lfo_depth, lfo_dir, cfg_pending);
  endtask

  // Write config with en low for two cycles so it commits and the LFO restarts.
  task automatic load_cfg(input int rate, input int mx);
    cfg_we = 1'b1; cfg_rate = 16'(rate); cfg_depth_max = 8'(mx); en = 1'b0;
    step();
    cfg_we = 1'b0;
    step();
    en = 1'b1;
    step();
  endtask

  int tri_exp[12] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4};
  int div_exp[9]  = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
  int pk2_exp[4]  = '{1, 2, 1, 0};

  initial begin
    // Reset
    repeat (3) step();
    chk("rst_depth", lfo_depth, 0);
    chk("rst_dir", lfo_dir, 1);
    chk("rst_bypass", bypass, 1);
    chk("rst_start", gain_start, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pending", cfg_pending, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b1;
    step();
    chk("rel_bypass", bypass, 1);
    // Write with en low: pending rises, commits on the following cycle.
    cfg_we = 1'b1; cfg_rate = 16'd1; cfg_depth_max = 8'd4;
    step();
    cfg_we = 1'b0;
    chk("cfg_pend_rise", cfg_pending, 1);
    step();
    chk("cfg_pend_commit", cfg_pending, 0);
    en = 1'b1;
    step();
    chk("en_bypass", bypass, 0);

    // Triangle rate=1 max=4
    for (int i = 0; i < 12; i++) run_sample(3, tri_exp[i], $sformatf("tri%0d", i));

    // Divider rate=3, then rate=0
    load_cfg(3, 4);
    for (int i = 0; i < 9; i++) run_sample(2, div_exp[i], $sformatf("div%0d", i));
    load_cfg(0, 4);
    for (int i = 0; i < 3; i++) run_sample(1, i + 1, $sformatf("r0_%0d", i));

    // Config commit at zero point
    load_cfg(1, 16);
    for (int i = 0; i < 3; i++) run_sample(1, i + 1, $sformatf("pk16_%0d", i));
    cfg_we = 1'b1; cfg_rate = 16'd1; cfg_depth_max = 8'd2;
    step();
    cfg_we = 1'b0;
    chk("pk_pend", cfg_pending, 1);
    for (int k = 4; k <= 32; k++) begin
      run_sample(1, (k <= 16) ? k : 32 - k, $sformatf("pk%0d", k));
      chk("pk_pend_k", cfg_pending, (k < 32) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) run_sample(1, pk2_exp[i], $sformatf("pk2_%0d", i));

    // Overrun and back-to-back
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("ovr_start", gain_start, 1);
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    chk("ovr_set", overrun, 1);
    chk("ovr_nostart", gain_start, 0);
    gain_done = 1'b1; sample_tick = 1'b1;
    step();
    gain_done = 1'b0; sample_tick = 1'b0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_start", gain_start, 1);
    chk("b2b_depth", lfo_depth, 1);
    $display("sample b2b depth=%0d start=%0d", lfo_depth, gain_start);
    step();
    gain_done = 1'b1;
    step();
    gain_done = 1'b0;
    chk("b2b2_valid", out_valid, 1);
    chk("b2b2_depth", lfo_depth, 2);
    chk("ovr_sticky", overrun, 1);

    // en drop mid-WAIT with pending config
    cfg_we = 1'b1; cfg_rate = 16'd1; cfg_depth_max = 8'd4;
    step();
    cfg_we = 1'b0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    en = 1'b0;
    step();
    chk("endrop_bypass", bypass, 1);
    chk("endrop_depth", lfo_depth, 0);
    chk("endrop_dir", lfo_dir, 1);
    chk("endrop_pend", cfg_pending, 0);
    gain_done = 1'b1;
    step();
    gain_done = 1'b0;
    chk("endrop_novalid", out_valid, 0);
    en = 1'b1;
    step();
    gain_done = 1'b1;
    step();
    gain_done = 1'b0;
    chk("late_done_novalid", out_valid, 0);
    chk("late_done_nostart", gain_start, 0);
    chk("ovr_final", overrun, 1);
    $display("sample endrop depth=%0d dir=%0d bypass=%0d", lfo_depth, lfo_dir, bypass);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
